alu_req_arbiter: RTL

//  Shares one 8-bit registered ALU between two requesters (req0, req1).

---
 rtl/alu_req_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester arbiter in front of a shared registered ALU: grants one op at a time and returns the result as a one-cycle pulse.
// Optional macro ALU_ARB_OPCHECK_EN: opcodes above MAX_OP are answered with rsp_err without using the ALU.
module alu_req_arbiter #(
    parameter int unsigned    WIDTH  = 8,
    parameter int unsigned    OPW    = 4,
    parameter logic [OPW-1:0] MAX_OP = OPW'(4'hA)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [OPW-1:0]   req0_op_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [OPW-1:0]   req1_op_i,
    output logic             rsp0_valid_o,
    output logic             rsp1_valid_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [OPW-1:0]   alu_select_o,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic             busy_o
);

`ifdef ALU_ARB_OPCHECK_EN
    localparam bit OPCHECK_EN = 1'b1;
`else
    localparam bit OPCHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp0_q, rsp0_d;
    logic             rsp1_q, rsp1_d;
    logic             rsp_err_q, rsp_err_d;
    logic             err_q, err_d;
    logic             grant_q, grant_d;
    logic             last_grant_q, last_grant_d;
    logic             busy_q, busy_d;

    logic             win0, win1;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [OPW-1:0]   sel_op;
    logic             op_bad;

    // Arbitration: a lone requester always wins; on a tie the one not granted last time wins.
    assign win1   = req1_valid_i && (!req0_valid_i || !last_grant_q);
    assign win0   = req0_valid_i && !win1;
    assign sel_a  = win1 ? req1_a_i  : req0_a_i;
    assign sel_b  = win1 ? req1_b_i  : req0_b_i;
    assign sel_op = win1 ? req1_op_i : req0_op_i;
    assign op_bad = OPCHECK_EN && (sel_op > MAX_OP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            rsp_data_q   <= '0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            rsp_err_q    <= 1'b0;
            err_q        <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_data_q   <= rsp_data_d;
            rsp0_q       <= rsp0_d;
            rsp1_q       <= rsp1_d;
            rsp_err_q    <= rsp_err_d;
            err_q        <= err_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_data_d   = rsp_data_q;
        rsp0_d       = 1'b0;
        rsp1_d       = 1'b0;
        rsp_err_d    = rsp_err_q;
        err_d        = err_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                req0_ready_o = win0;
                req1_ready_o = win1;
                if (win0 || win1) begin
                    grant_d      = win1;
                    last_grant_d = win1;
                    err_d        = op_bad;
                    if (op_bad) begin
                        // Illegal op skips the ALU entirely; its inputs keep their old values.
                        state_d = CAPTURE;
                    end else begin
                        alu_a_d   = sel_a;
                        alu_b_d   = sel_b;
                        alu_sel_d = sel_op;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_data_d = err_q ? '0 : alu_result_i;
                rsp_err_d  = err_q;
                rsp0_d     = !grant_q;
                rsp1_d     = grant_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_select_o = alu_sel_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp0_valid_o = rsp0_q;
    assign rsp1_valid_o = rsp1_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = busy_q;

endmodule
